vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vending_machine_param.sv | 122 ++++++++++++
 tb/tb_vending_machine_param.sv | 130 +++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// -----------------------------------------------------------------------------
// vending_machine_param
//   Coin-operated vending controller. Credit is accumulated in 5-cent units.
//   When credit reaches PRICE it vends one product. Any excess is then returned
//   one coin per cycle, choosing the largest coin first.
//   Cancel refunds all accumulated credit, plus any coin presented in the same
//   cycle. A cancel always takes priority over a vend.
//
// Parameters
//   PRICE  product price in 5-cent units (1..30)
//   CW     width of the credit/change registers; must be able to hold PRICE+4
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   moeda   coin in: 00 none, 01 5c, 10 10c, 11 25c
//   cancel  refund request, level-sampled each cycle
//   D1      dispense pulse, one cycle per vend
//   T       change coin emitted this cycle (same coding as moeda)
//   busy    high while in VEND or CHANGE
//   rej     coin presented while busy (the coin is not credited)
// -----------------------------------------------------------------------------
module vending_machine_param #(
   parameter int PRICE = 5,
   parameter int CW    = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] moeda,
   input  logic       cancel,
   output logic       D1,
   output logic [1:0] T,
   output logic       busy,
   output logic       rej
);

   typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   credit, credit_n;
   logic [CW-1:0]   change, change_n;
   logic [CW-1:0]   total;
   logic [1:0]      chg_coin;

   // Value of a coin code, in 5-cent units.
   function automatic logic [CW-1:0] coin_val(input logic [1:0] c);
      case (c)
         2'b01:   return CW'(1);
         2'b10:   return CW'(2);
         2'b11:   return CW'(5);
         default: return '0;
      endcase
   endfunction

   // Greedy change selection: return the largest coin that still fits.
   always_comb begin
      chg_coin = 2'b00;
      if (change >= CW'(5))      chg_coin = 2'b11;
      else if (change >= CW'(2)) chg_coin = 2'b10;
      else if (change != '0)     chg_coin = 2'b01;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= COLLECT;
         credit <= '0;
         change <= '0;
      end else begin
         state  <= state_n;
         credit <= credit_n;
         change <= change_n;
      end
   end

   always_comb begin
      state_n  = state;
      credit_n = credit;
      change_n = change;
      // Credit never exceeds PRICE-1 and a coin adds at most 5, so the total
      // is bounded by PRICE+4 and fits in CW bits.
      total    = credit + coin_val(moeda);
      case (state)
         COLLECT: begin
            if (cancel) begin
               // Refund takes priority over vending, even when this coin
               // would complete the price.
               if (total != '0) begin
                  state_n  = CHANGE;
                  change_n = total;
                  credit_n = '0;
               end
            end else if (moeda != 2'b00) begin
               if (total >= CW'(PRICE)) begin
                  state_n  = VEND;
                  credit_n = '0;
                  change_n = total - CW'(PRICE);
               end else begin
                  credit_n = total;
               end
            end
         end
         VEND: begin
            state_n = (change != '0) ? CHANGE : COLLECT;
         end
         CHANGE: begin
            change_n = change - coin_val(chg_coin);
            if (change_n == '0) state_n = COLLECT;
         end
         default: begin
            state_n = COLLECT;
         end
      endcase
   end

   // Outputs are decoded from registered state only. The exception is rej,
   // which must flag the coin in the same cycle it is presented.
   assign D1   = (state == VEND);
   assign busy = (state != COLLECT);
   assign T    = (state == CHANGE) ? chg_coin : 2'b00;
   assign rej  = busy && (moeda != 2'b00);

endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] moeda;
   logic       cancel;
   logic       D1;
   logic [1:0] T;
   logic       busy;
   logic       rej;

   int checks   = 0;
   int failures = 0;

   vending_machine_param #(.PRICE(5), .CW(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .moeda  (moeda),
      .cancel (cancel),
      .D1     (D1),
      .T      (T),
      .busy   (busy),
      .rej    (rej)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic d1_e, input logic [1:0] t_e,
                          input logic busy_e);
      chk({tag, ".D1"},   {7'd0, D1},   {7'd0, d1_e});
      chk({tag, ".T"},    {6'd0, T},    {6'd0, t_e});
      chk({tag, ".busy"}, {7'd0, busy}, {7'd0, busy_e});
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; moeda = 2'b00; cancel = 1'b0;
      #2;
      chk_out("reset", 1'b0, 2'b00, 1'b0);
      chk("reset.rej", {7'd0, rej}, 8'd0);
      tick();
      rst = 1'b0;

      // Single 25c from reset: exact price, vend with no change.
      moeda = 2'b11; tick(); moeda = 2'b00;
      chk_out("q25.vend", 1'b1, 2'b00, 1'b1);
      tick();
      chk_out("q25.idle", 1'b0, 2'b00, 1'b0);
      chk("q25.credit", {2'd0, dut.credit}, 8'd0);

      // Three 10c coins: sum 6, vend, then one 5c back.
      moeda = 2'b10; tick();
      chk_out("d3.c1", 1'b0, 2'b00, 1'b0);
      tick();
      chk_out("d3.c2", 1'b0, 2'b00, 1'b0);
      tick(); moeda = 2'b00;
      chk_out("d3.vend", 1'b1, 2'b00, 1'b1);
      tick();
      chk_out("d3.chg", 1'b0, 2'b01, 1'b1);
      // A 5c coin during CHANGE is rejected and not credited.
      moeda = 2'b01; #1;
      chk("d3.rej", {7'd0, rej}, 8'd1);
      tick(); moeda = 2'b00; #1;
      chk_out("d3.idle", 1'b0, 2'b00, 1'b0);
      chk("d3.rej0", {7'd0, rej}, 8'd0);
      chk("d3.credit", {2'd0, dut.credit}, 8'd0);

      // 10c then 25c: sum 7, vend, then one 10c back.
      moeda = 2'b10; tick();
      moeda = 2'b11; tick(); moeda = 2'b00;
      chk_out("dq.vend", 1'b1, 2'b00, 1'b1);
      tick();
      chk_out("dq.chg", 1'b0, 2'b10, 1'b1);
      tick();
      chk_out("dq.idle", 1'b0, 2'b00, 1'b0);

      // 5c, 10c, then cancel: refund 3 units as 10c + 5c, no vend.
      // Cancel is held high throughout CHANGE, where it must be ignored.
      moeda = 2'b01; tick();
      moeda = 2'b10; tick();
      moeda = 2'b00; cancel = 1'b1; tick();
      chk_out("cx.chg1", 1'b0, 2'b10, 1'b1);
      tick();
      chk_out("cx.chg2", 1'b0, 2'b01, 1'b1);
      tick();
      chk_out("cx.idle", 1'b0, 2'b00, 1'b0);
      // Cancel with zero credit and no coin has no effect.
      tick();
      chk_out("cx.noop", 1'b0, 2'b00, 1'b0);

      // Cancel together with a 25c coin: the refund wins over the vend.
      moeda = 2'b11; tick(); moeda = 2'b00; cancel = 1'b0;
      chk_out("cq.chg", 1'b0, 2'b11, 1'b1);
      tick();
      chk_out("cq.idle", 1'b0, 2'b00, 1'b0);

      // 10c then 25c, then reset during CHANGE abandons the refund.
      moeda = 2'b10; tick();
      moeda = 2'b11; tick(); moeda = 2'b00;
      chk_out("rs.vend", 1'b1, 2'b00, 1'b1);
      tick();
      chk_out("rs.chg", 1'b0, 2'b10, 1'b1);
      rst = 1'b1; #1;
      chk_out("rs.async", 1'b0, 2'b00, 1'b0);
      tick();
      chk_out("rs.held", 1'b0, 2'b00, 1'b0);
      rst = 1'b0; moeda = 2'b11; tick(); moeda = 2'b00;
      chk_out("rs.vend2", 1'b1, 2'b00, 1'b1);
      tick();
      chk_out("rs.idle", 1'b0, 2'b00, 1'b0);
      chk("rs.change", {2'd0, dut.change}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
